uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Serial transmit stage that consumes the single-cycle `tick` strobe from the baud rate generator.
- Tick runs at OVERSAMPLE × baud rate; the block counts OVERSAMPLE ticks per bit time.
- Takes a parallel byte via a ready/write handshake and serialises it onto `txd`: start bit, data bits LSB first, optional parity bit, stop bit(s).
- Drives `baud_en` back to the generator, so the generator only runs while a frame is in flight.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- OVERSAMPLE, 16, ticks per bit time; legal range 1..256.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- CLK50MHZ  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle strobe from the baud generator, OVERSAMPLE per bit.
- data  in  DATA_BITS  byte to transmit; sampled only on an accepted write.
- wr  in  1  write strobe.
- ready  out  1  high when idle and able to accept a write.
- baud_en  out  1  enable to the baud generator; high for the whole frame.
- txd  out  1  serial line, idle high; registered output.

Behaviour:
- Reset: synchronous. On any edge with RST=1:
  - state = IDLE; txd = 1; ready = 1; baud_en = 0.
  - Tick counter, bit counter and shift register cleared.
  - RST has priority over every other input.
  - RST mid-frame aborts the frame: txd returns to 1 on that edge, and nothing resumes after reset.
- States: IDLE → START → DATA → PARITY (only when PARITY≠0) → STOP → IDLE.
- ready = (state == IDLE), combinational from the state register. baud_en = (state ≠ IDLE), registered.
- Write acceptance: a write is accepted on an edge where wr=1 and ready=1.
  - On that edge: data latched into the shift register; parity computed over the latched data and stored (even: XOR of the bits; odd: its inverse).
  - Same edge: state → START, txd ← 0, tick counter ← 0.
  - Result: txd falls exactly 1 cycle after the accepted wr, and ready is low from that cycle.
- wr while ready=0: ignored; no queuing; `data` is not sampled.
- Tick counting: ticks are ignored in IDLE, including a tick in the same cycle as an accepted wr. In any other state, each tick increments the tick counter (width clog2(OVERSAMPLE), minimum 1 bit). When a tick arrives with counter = OVERSAMPLE-1, the counter wraps to 0 and the bit ends:
  - START end: → DATA; txd ← shift[0].
  - DATA end: shift right, bit counter +1. If DATA_BITS bits are done: → PARITY (txd ← parity bit), or → STOP (txd ← 1) when PARITY=0. Otherwise txd ← next bit.
  - PARITY end: → STOP; txd ← 1.
  - STOP end: stop-bit counter +1. When STOP_BITS stop bits are done: → IDLE, baud_en ← 0, txd stays 1.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × OVERSAMPLE ticks, counted from the first tick after acceptance.
- Back-to-back frames: ready rises the cycle after the final stop tick. A wr in that cycle starts the next frame immediately, and baud_en is high again on the following edge.
- Boundaries:
  - tick high every cycle is legal; each bit then lasts OVERSAMPLE cycles.
  - A tick on the same edge as RST is ignored.
  - OVERSAMPLE=1: every tick ends a bit.
  - `data` changing during a frame has no effect.

Test Plan:
- 8N1, OVERSAMPLE=16, tick every 4 cycles, wr with data=0x55:
  - txd falls 1 cycle after wr.
  - Bit sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly 64 cycles.
  - ready low for 640 cycles, then high; baud_en mirrors ~ready.
- PARITY=1 with data=0x07 → parity bit 1. PARITY=2 with data=0x07 → parity bit 0. STOP_BITS=2 → txd high for 2 bit times before ready rises.
- wr pulsed with data=0xFF mid-frame of 0x00 → line carries only the 0x00 frame; no second frame follows.
- RST asserted during data bit 3 → next edge: txd=1, ready=1, baud_en=0. A following wr with 0xA5 transmits a clean full frame.
- Back-to-back: wr held high with data 0x12 then 0x34 → second start bit begins 1 cycle after ready rises, with no extra idle bit time.
- OVERSAMPLE=1, tick tied high, wr with data=0x80 → 10-cycle frame, where txd is high only on data bit 7 and the stop bit.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a parallel word over a ready/write handshake
// and shifts it out as start bit, data bits LSB first, optional parity bit
// and one or two stop bits. Bit timing comes from an external tick strobe
// running at OVERSAMPLE ticks per bit; baud_en keeps that generator running
// only while a frame is in flight.
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK50MHZ,
    input  logic                 RST,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 wr,
    output logic                 ready,
    output logic                 baud_en,
    output logic                 txd
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state_q,   state_d;
    logic [TW-1:0]        tickCnt_q, tickCnt_d;
    logic [2:0]           bitCnt_q,  bitCnt_d;
    logic                 stopCnt_q, stopCnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic                 txd_q,     txd_d;
    logic                 baudEn_q,  baudEn_d;

    // Next-state logic: handshake in IDLE, tick-driven bit sequencing elsewhere.
    always_comb begin
        state_d   = state_q;
        tickCnt_d = tickCnt_q;
        bitCnt_d  = bitCnt_q;
        stopCnt_d = stopCnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        baudEn_d  = baudEn_q;

        if (state_q == ST_IDLE) begin
            if (wr) begin
                shift_d   = data;
                parity_d  = (PARITY == 2) ? ~(^data) : (^data);
                state_d   = ST_START;
                txd_d     = 1'b0;
                tickCnt_d = '0;
                bitCnt_d  = '0;
                stopCnt_d = 1'b0;
                baudEn_d  = 1'b1;
            end
        end else if (tick) begin
            if (tickCnt_q == TICK_LAST) begin
                tickCnt_d = '0;
                case (state_q)
                    ST_START: begin
                        state_d = ST_DATA;
                        txd_d   = shift_q[0];
                    end
                    ST_DATA: begin
                        shift_d  = shift_q >> 1;
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == BIT_LAST) begin
                            if (PARITY != 0) begin
                                state_d = ST_PARITY;
                                txd_d   = parity_q;
                            end else begin
                                state_d = ST_STOP;
                                txd_d   = 1'b1;
                            end
                        end else begin
                            txd_d = shift_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end
                    ST_STOP: begin
                        if (stopCnt_q == STOP_LAST) begin
                            state_d   = ST_IDLE;
                            baudEn_d  = 1'b0;
                            txd_d     = 1'b1;
                            stopCnt_d = 1'b0;
                        end else begin
                            stopCnt_d = stopCnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        baudEn_d = 1'b0;
                        txd_d    = 1'b1;
                    end
                endcase
            end else begin
                tickCnt_d = tickCnt_q + TW'(1);
            end
        end
    end

    // State registers; reset wins over everything and aborts any frame.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tickCnt_q <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            baudEn_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tickCnt_q <= tickCnt_d;
            bitCnt_q  <= bitCnt_d;
            stopCnt_q <= stopCnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            baudEn_q  <= baudEn_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign baud_en = baudEn_q;
    assign txd     = txd_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four instances cover 8N1 with a gated 1-in-4
// tick, even parity, odd parity with two stop bits, and OVERSAMPLE=1.
// Expected line bits are queued when a write is driven and popped as the
// line is sampled bit by bit.
module tb_uart_tx_framer;

    logic       clk;
    logic       RST;
    logic [7:0] data;
    logic [3:0] wrV;
    logic [3:0] txdV;
    logic [3:0] readyV;
    logic [3:0] baudV;
    logic       tickA;
    logic [1:0] divA;

    int compared;
    int mismatched;
    logic expQ[$];

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [11:0] bits;
        int         nbits;
        int         cpb;
    } vec_t;

    vec_t vecs[7];

    uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dutA (
        .CLK50MHZ(clk), .RST(RST), .tick(tickA), .data(data), .wr(wrV[0]),
        .ready(readyV[0]), .baud_en(baudV[0]), .txd(txdV[0]));

    uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(1), .STOP_BITS(1)) dutB (
        .CLK50MHZ(clk), .RST(RST), .tick(1'b1), .data(data), .wr(wrV[1]),
        .ready(readyV[1]), .baud_en(baudV[1]), .txd(txdV[1]));

    uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(2), .STOP_BITS(2)) dutC (
        .CLK50MHZ(clk), .RST(RST), .tick(1'b1), .data(data), .wr(wrV[2]),
        .ready(readyV[2]), .baud_en(baudV[2]), .txd(txdV[2]));

    uart_tx_framer #(.DATA_BITS(8), .OVERSAMPLE(1), .PARITY(0), .STOP_BITS(1)) dutD (
        .CLK50MHZ(clk), .RST(RST), .tick(1'b1), .data(data), .wr(wrV[3]),
        .ready(readyV[3]), .baud_en(baudV[3]), .txd(txdV[3]));

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud generator for dutA: one tick every 4 cycles, held in reset while baud_en is low.
    initial begin
        divA  = 2'd0;
        tickA = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!baudV[0]) divA = 2'd0;
            else           divA = divA + 2'd1;
            tickA = baudV[0] && (divA == 2'd0);
        end
    end

    task automatic pushFrame(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(bits[i]);
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] d, input logic [11:0] bits,
                                 input int n, input bit hold);
        pushFrame(bits, n);
        @(negedge clk);
        data     = d;
        wrV[sel] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) wrV[sel] = 1'b0;
    endtask

    task automatic checkOutput(input int sel, input int nbits, input int cpb, input bit scramble);
        int badFlags;
        badFlags = 0;
        for (int i = 0; i < nbits; i++) begin
            logic expBit;
            logic seen;
            int   badCyc;
            badCyc = 0;
            seen   = 1'b0;
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL queueEmpty dut%0d bit%0d: no expected value queued", sel, i);
                expBit = 1'b1;
            end else begin
                expBit = expQ.pop_front();
            end
            for (int c = 0; c < cpb; c++) begin
                if (txdV[sel] !== expBit) begin
                    badCyc++;
                    seen = txdV[sel];
                end
                if (readyV[sel] !== 1'b0 || baudV[sel] !== 1'b1) badFlags++;
                if (scramble && c == cpb / 2) data = 8'($urandom);
                @(posedge clk);
                #1;
            end
            compared++;
            if (badCyc != 0) begin
                mismatched++;
                $display("[TB] FAIL lineBit dut%0d bit%0d: txd=%b on %0d of %0d cycles, expected %b",
                         sel, i, seen, badCyc, cpb, expBit);
            end
        end
        compared++;
        if (badFlags != 0) begin
            mismatched++;
            $display("[TB] FAIL busyFlags dut%0d: ready/baud_en wrong on %0d cycles, expected ready=0 baud_en=1",
                     sel, badFlags);
        end
        compared++;
        if (readyV[sel] !== 1'b1 || baudV[sel] !== 1'b0 || txdV[sel] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL frameEnd dut%0d: ready=%b baud_en=%b txd=%b, expected 1 0 1",
                     sel, readyV[sel], baudV[sel], txdV[sel]);
        end
    endtask

    task automatic checkIdle(input int sel, input int cycles, input string name);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            if (txdV[sel] !== 1'b1 || readyV[sel] !== 1'b1 || baudV[sel] !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d: line not idle on %0d of %0d cycles, expected txd=1 ready=1 baud_en=0",
                     name, sel, bad, cycles);
        end
    endtask

    // Main sequence: reset, vector table, then the multi-cycle corner cases.
    initial begin
        compared   = 0;
        mismatched = 0;
        RST        = 1'b1;
        wrV        = 4'b0;
        data       = 8'h00;

        vecs[0] = '{0, 8'h55, 12'h2AA, 10, 64};
        vecs[1] = '{1, 8'h07, 12'h60E, 11, 4};
        vecs[2] = '{2, 8'h07, 12'hC0E, 12, 4};
        vecs[3] = '{3, 8'h80, 12'h300, 10, 1};
        vecs[4] = '{1, 8'h00, 12'h400, 11, 4};
        vecs[5] = '{2, 8'hA5, 12'hF4A, 12, 4};
        vecs[6] = '{3, 8'h3C, 12'h278, 10, 1};

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            compared++;
            if (txdV[s] !== 1'b1 || readyV[s] !== 1'b1 || baudV[s] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL resetState dut%0d: txd=%b ready=%b baud_en=%b, expected 1 1 0",
                         s, txdV[s], readyV[s], baudV[s]);
            end
        end
        @(negedge clk);
        RST = 1'b0;
        checkIdle(3, 5, "idleTicksIgnored");

        $display("[TB] vector table");
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].sel, vecs[v].data, vecs[v].bits, vecs[v].nbits, 1'b0);
            checkOutput(vecs[v].sel, vecs[v].nbits, vecs[v].cpb, 1'b1);
        end

        $display("[TB] write during busy frame");
        applyStimulus(0, 8'h00, 12'h200, 10, 1'b0);
        fork
            checkOutput(0, 10, 64, 1'b0);
            begin
                repeat (200) @(negedge clk);
                data   = 8'hFF;
                wrV[0] = 1'b1;
                @(negedge clk);
                wrV[0] = 1'b0;
            end
        join
        checkIdle(0, 192, "noSecondFrame");

        $display("[TB] reset during data bit 3");
        applyStimulus(0, 8'h00, 12'h000, 0, 1'b0);
        repeat (4 * 64 + 20) @(posedge clk);
        #1;
        compared++;
        if (txdV[0] !== 1'b0 || readyV[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL preReset: txd=%b ready=%b, expected 0 0", txdV[0], readyV[0]);
        end
        @(negedge clk);
        RST = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (txdV[0] !== 1'b1 || readyV[0] !== 1'b1 || baudV[0] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midFrameReset: txd=%b ready=%b baud_en=%b, expected 1 1 0",
                     txdV[0], readyV[0], baudV[0]);
        end
        @(negedge clk);
        RST = 1'b0;
        checkIdle(0, 100, "noResume");
        applyStimulus(0, 8'hA5, 12'h34A, 10, 1'b0);
        checkOutput(0, 10, 64, 1'b1);

        $display("[TB] back-to-back frames with wr held");
        applyStimulus(0, 8'h12, 12'h224, 10, 1'b1);
        data = 8'h34;
        pushFrame(12'h268, 10);
        checkOutput(0, 10, 64, 1'b0);
        @(posedge clk);
        #1;
        wrV[0] = 1'b0;
        checkOutput(0, 10, 64, 1'b1);
        checkIdle(0, 10, "afterBackToBack");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
